uart_tx_fifo_engine: RTL
========================

# uart_tx_fifo_engine

Parametrised UART transmitter that buffers user bytes in an internal FIFO and serialises them with a runtime-selectable baud divisor, data width, parity mode and stop-bit count. It is the next-generation transmit half of the UART driver. It sits between the user valid/ready interface and the `o_uart_tx` pin, and sustains back-to-back frames without user-side stalls until the FIFO fills.

## Interface
- `P_DATA_WIDTH`, 8: maximum data bits per frame; FIFO word width.
- `P_FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `P_DIV_WIDTH`, 16: width of the baud divisor.
- `clock` input 1: single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `i_baud_div` input `P_DIV_WIDTH`: bit period is `i_baud_div`+1 clocks. Values < 1 are treated as 1.
- `i_data_bits` input 4: data bits per frame, 5..`P_DATA_WIDTH`. Values < 5 are treated as 5; values > `P_DATA_WIDTH` are treated as `P_DATA_WIDTH`.
- `i_stop_bits` input 2: 0 or 1 selects one stop bit; 2 or 3 selects two.
- `i_check_bits` input 2: 0 or 3 = no parity, 1 = odd, 2 = even.
- `i_user_tx_data` input `P_DATA_WIDTH`: byte to send; upper bits beyond `i_data_bits` are ignored.
- `i_user_tx_valid` input 1: data valid.
- `o_user_tx_ready` output 1: FIFO not full.
- `o_uart_tx` output 1: serial line, registered, idles high.
- `o_tx_busy` output 1: a frame is in progress (FSM not IDLE).
- `o_tx_done` output 1: one-cycle pulse in the last clock of the final stop bit.
- `o_fifo_level` output clog2(`P_FIFO_DEPTH`)+1: number of occupied entries.

## Operation
- A push occurs when `i_user_tx_valid` and `o_user_tx_ready` are both high on a rising clock edge. Valid is ignored while ready is low, so no overflow is possible.
- FIFO: circular buffer with write/read pointers one bit wider than the index; full/empty derive from the pointers. A simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and latch the divisor, data bits, parity mode and stop count, then go to START. Otherwise stay in IDLE.
  - START: drive 0 for one bit period, then go to DATA.
  - DATA: send LSB first, for the latched data-bit count. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: drive the XOR of the sent data bits for even parity, or its inverse for odd parity, for one bit period.
  - STOP: drive 1 for 1 or 2 bit periods, then return to IDLE. `o_tx_done` pulses in the last cycle.
- Baud counter: counts 0..latched divisor, and a bit ends when it reaches the latched divisor. Changing the config inputs mid-frame has no effect until the next IDLE→START transition.
- `o_uart_tx` is a register. It is 1 in IDLE, and the line value for each state is registered on entry.

## Timing
- Reset values: `o_uart_tx`=1, `o_user_tx_ready`=1, `o_tx_busy`=0, `o_tx_done`=0, `o_fifo_level`=0. The FIFO pointers and FSM are cleared to IDLE.
- Reset asserted mid-frame drives the line high immediately (asynchronously) and discards both the FIFO contents and the frame in progress.
- Latency, push at edge N into an empty FIFO with the FSM in IDLE:
  - level = 1 after edge N;
  - pop at edge N+1;
  - `o_uart_tx`=0 and `o_tx_busy`=1 after edge N+1;
  - level returns to 0 after edge N+1.
- Frame length is (1 + data + parity + stop) × (div+1) clocks.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when the FIFO is non-empty. The gap between the end of a stop bit and the next start bit is therefore one clock.
- `o_user_tx_ready` drops after the edge that makes the level equal `P_FIFO_DEPTH`. It rises after the pop edge that frees a slot.
- Level arithmetic is modulo 2^(clog2(`P_FIFO_DEPTH`)+1). Pointer wrap-around is exercised after `P_FIFO_DEPTH` pushes.

## Configuration
- Macro `UART_TX_PARITY_EN`.
  - Defined: the PARITY state and the `i_check_bits` decoding are present, as described above.
  - Undefined: the PARITY state and parity logic are removed and `i_check_bits` is ignored. DATA always goes to STOP, and frames never carry a parity bit.

## Test plan
- 8N1, `i_baud_div`=3, push 0x55: the line shows start 0, then 1,0,1,0,1,0,1,0, then stop 1. Each bit lasts 4 clocks, and `o_tx_done` pulses at clock 40 after the start bit begins.
- 7E2, `i_baud_div`=1, push 0x03 (with `UART_TX_PARITY_EN`): data 1,1,0,0,0,0,0, then parity 0, then two stop bits. The frame is 11 bits = 22 clocks.
- 5O1, push 0xFF: only five 1s are sent, followed by parity 0, because the five 1s already give odd parity.
- Push 17 bytes 0x00..0x10 continuously with depth 16:
  - ready drops once level = 16;
  - all 17 bytes are serialised in order;
  - each inter-frame gap is exactly 1 clock.
- Assert reset mid-DATA of 0xA5 with 3 bytes queued: the line goes high immediately, level = 0, busy = 0, and no further frames follow after reset is released.
- Change `i_baud_div` from 3 to 7 mid-frame: the current frame keeps 4-clock bits, and the next frame uses 8-clock bits.

Source files
------------

// File: rtl/uart_tx_fifo_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_engine
// Brief    : FIFO-buffered UART transmitter with runtime baud/format config.
//            Optional parity generation is enabled by macro UART_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo_engine #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_DIV_WIDTH  = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [P_DIV_WIDTH-1:0]            i_baud_div,
    input  logic [3:0]                        i_data_bits,
    input  logic [1:0]                        i_stop_bits,
    input  logic [1:0]                        i_check_bits,
    input  logic [P_DATA_WIDTH-1:0]           i_user_tx_data,
    input  logic                              i_user_tx_valid,
    output logic                              o_user_tx_ready,
    output logic                              o_uart_tx,
    output logic                              o_tx_busy,
    output logic                              o_tx_done,
    output logic [$clog2(P_FIFO_DEPTH):0]     o_fifo_level
);

    localparam int c_AW    = $clog2(P_FIFO_DEPTH);
    localparam int c_PTR_W = c_AW + 1;
    localparam int c_NB_W  = $clog2(P_DATA_WIDTH + 1);

    localparam logic [c_PTR_W-1:0]     c_PTR_ONE = c_PTR_W'(1);
    localparam logic [P_DIV_WIDTH-1:0] c_DIV_ONE = P_DIV_WIDTH'(1);
    localparam logic [c_NB_W-1:0]      c_CNT_ONE = c_NB_W'(1);
    localparam logic [c_NB_W-1:0]      c_CNT_TWO = c_NB_W'(2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t                   r_state;
    state_t                   w_state_next;

    logic [P_DATA_WIDTH-1:0]  r_mem [P_FIFO_DEPTH];
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_PTR_W-1:0]       w_level;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;

    logic [P_DATA_WIDTH-1:0]  r_shift;
    logic [P_DIV_WIDTH-1:0]   r_div;
    logic [P_DIV_WIDTH-1:0]   r_baud_cnt;
    logic [c_NB_W-1:0]        r_nbits;
    logic [c_NB_W-1:0]        r_bit_cnt;
    logic                     r_two_stop;
    logic                     r_tx;

    logic [P_DIV_WIDTH-1:0]   w_div_eff;
    logic [c_NB_W-1:0]        w_nbits;
    logic                     w_tick;
    logic                     w_last_data;
    logic                     w_last_stop;
    logic                     w_done;

`ifdef UART_TX_PARITY_EN
    logic                     r_par_en;
    logic                     r_par_odd;
    logic                     r_par_acc;
`else
    logic                     w_unused_check;
    assign w_unused_check = ^i_check_bits;
`endif

    // FIFO: pointers carry an extra wrap bit so full and empty are distinct
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push  = i_user_tx_valid && !w_full;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_user_tx_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Configuration sanitising, sampled only when a frame is launched
    assign w_div_eff = (i_baud_div == '0) ? c_DIV_ONE : i_baud_div;

    always_comb begin
        if (i_data_bits < 4'd5) begin
            w_nbits = c_NB_W'(5);
        end else if ({28'd0, i_data_bits} > 32'(P_DATA_WIDTH)) begin
            w_nbits = c_NB_W'(P_DATA_WIDTH);
        end else begin
            w_nbits = c_NB_W'(i_data_bits);
        end
    end

    assign w_tick      = (r_baud_cnt == r_div);
    assign w_last_data = (r_bit_cnt == r_nbits);
    assign w_last_stop = r_two_stop ? (r_bit_cnt == c_CNT_TWO) : (r_bit_cnt == c_CNT_ONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_tick && w_last_data) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick && w_last_stop) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: the line value of each bit is loaded on the edge that enters it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_div      <= '0;
            r_nbits    <= '0;
            r_two_stop <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_par_acc  <= 1'b0;
`endif
        end else begin
            if ((r_state == S_IDLE) || w_tick) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + c_DIV_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_tx       <= 1'b0;
                        r_shift    <= r_mem[r_rd_ptr[c_AW-1:0]];
                        r_div      <= w_div_eff;
                        r_nbits    <= w_nbits;
                        r_two_stop <= (i_stop_bits > 2'd1);
`ifdef UART_TX_PARITY_EN
                        r_par_en   <= (i_check_bits == 2'd1) || (i_check_bits == 2'd2);
                        r_par_odd  <= (i_check_bits == 2'd1);
                        r_par_acc  <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= c_CNT_ONE;
`ifdef UART_TX_PARITY_EN
                        r_par_acc <= r_shift[0];
`endif
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (w_last_data) begin
`ifdef UART_TX_PARITY_EN
                            if (r_par_en) begin
                                r_tx <= r_par_acc ^ r_par_odd;
                            end else begin
                                r_tx      <= 1'b1;
                                r_bit_cnt <= c_CNT_ONE;
                            end
`else
                            r_tx      <= 1'b1;
                            r_bit_cnt <= c_CNT_ONE;
`endif
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
`ifdef UART_TX_PARITY_EN
                            r_par_acc <= r_par_acc ^ r_shift[0];
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_tx      <= 1'b1;
                        r_bit_cnt <= c_CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick && !w_last_stop) begin
                        r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign o_uart_tx       = r_tx;
    assign o_user_tx_ready = !w_full;
    assign o_tx_busy       = (r_state != S_IDLE);
    assign o_tx_done       = w_done;
    assign o_fifo_level    = w_level;

endmodule
`default_nettype wire
